// File: rtl/coin_conditioner.sv
// -----------------------------------------------------------------------------
// coin_conditioner
//
// Turns three raw, asynchronous, bouncy coin-sensor lines into clean
// one-cycle coin pulses for the vending-machine FSM. Each line goes through a
// two-flop synchronizer and a debounce filter. A rising debounced edge is a
// coin event, which is queued in a small per-denomination pending counter.
// One queued coin is released per clock, with priority Q > D > N, while the
// downstream FSM is not holding us off.
//
// Ports
//   clk          : system clock, rising-edge active
//   reset        : synchronous, active-low reset
//   n_raw        : nickel sensor (async, active-high, bouncy)
//   d_raw        : dime sensor (async, active-high, bouncy)
//   q_raw        : quarter sensor (async, active-high, bouncy)
//   hold         : downstream busy; no pulses are emitted while high
//   N, D, Q      : registered one-cycle coin pulses, mutually exclusive
//   coin_pending : registered, high while any pending counter is nonzero
//   overflow     : sticky, set when a coin is lost to counter saturation
// -----------------------------------------------------------------------------
module coin_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PEND_MAX        = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic n_raw,
   input  logic d_raw,
   input  logic q_raw,
   input  logic hold,
   output logic N,
   output logic D,
   output logic Q,
   output logic coin_pending,
   output logic overflow
);

   // Channel index: 0 = nickel, 1 = dime, 2 = quarter.
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] P_MAX   = 2'(PEND_MAX);

   logic [2:0] w_raw;
   logic [2:0] r_s1;
   logic [2:0] r_s2;
   logic [2:0] r_stable;
   logic [3:0] r_dbcnt [3];
   logic [1:0] r_pend  [3];
   logic [2:0] r_pulse;
   logic       r_coin_pending;
   logic       r_overflow;

   logic [2:0] w_event;
   logic [2:0] w_nonzero;
   logic [2:0] w_sel;
   logic [2:0] w_ovf_hit;
   logic [1:0] w_pend_nxt [3];

   // Fixed-priority one-hot pick of the channel to emit this edge.
   function automatic logic [2:0] f_pick(input logic i_hold, input logic [2:0] i_nz);
      logic [2:0] v;
      v = 3'b000;
      if (!i_hold) begin
         if (i_nz[2])      v = 3'b100;
         else if (i_nz[1]) v = 3'b010;
         else if (i_nz[0]) v = 3'b001;
      end
      return v;
   endfunction

   // Next pending count; a simultaneous event and emission cancel out, and an
   // event into a full counter is dropped (reported through o_lost).
   function automatic logic [1:0] f_pend_next(input logic [1:0] i_cnt, input logic i_ev,
                                              input logic i_em, output logic o_lost);
      logic [1:0] v;
      v      = i_cnt;
      o_lost = 1'b0;
      case ({i_ev, i_em})
         2'b10: begin
            if (i_cnt == P_MAX) o_lost = 1'b1;
            else                v      = i_cnt + 2'd1;
         end
         2'b01:   v = i_cnt - 2'd1;
         default: v = i_cnt;
      endcase
      return v;
   endfunction

   assign w_raw = {q_raw, d_raw, n_raw};

   always_comb begin
      w_event   = '0;
      w_nonzero = '0;
      w_ovf_hit = '0;
      for (int i = 0; i < 3; i++) begin
         w_pend_nxt[i] = r_pend[i];
      end
      for (int i = 0; i < 3; i++) begin
         // The event fires on the same edge that flips stable from 0 to 1.
         w_event[i]   = r_s2[i] && !r_stable[i] && (r_dbcnt[i] == DB_LAST);
         w_nonzero[i] = (r_pend[i] != 2'd0);
      end
      w_sel = f_pick(hold, w_nonzero);
      for (int i = 0; i < 3; i++) begin
         w_pend_nxt[i] = f_pend_next(r_pend[i], w_event[i], w_sel[i], w_ovf_hit[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1           <= '0;
         r_s2           <= '0;
         r_stable       <= '0;
         r_pulse        <= '0;
         r_coin_pending <= 1'b0;
         r_overflow     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_dbcnt[i] <= '0;
            r_pend[i]  <= '0;
         end
      end else begin
         // Synchronizer stage
         r_s1 <= w_raw;
         r_s2 <= r_s1;
         // Debounce / pending stage
         for (int i = 0; i < 3; i++) begin
            if (r_s2[i] == r_stable[i]) begin
               r_dbcnt[i] <= '0;
            end else if (r_dbcnt[i] == DB_LAST) begin
               r_stable[i] <= r_s2[i];
               r_dbcnt[i]  <= '0;
            end else begin
               r_dbcnt[i] <= r_dbcnt[i] + 4'd1;
            end
            r_pend[i] <= w_pend_nxt[i];
         end
         // Output stage
         r_pulse        <= w_sel;
         r_coin_pending <= (w_pend_nxt[0] != 2'd0) || (w_pend_nxt[1] != 2'd0) ||
                           (w_pend_nxt[2] != 2'd0);
         r_overflow     <= r_overflow | (|w_ovf_hit);
      end
   end

   assign N            = r_pulse[0];
   assign D            = r_pulse[1];
   assign Q            = r_pulse[2];
   assign coin_pending = r_coin_pending;
   assign overflow     = r_overflow;

endmodule

// File: doc/coin_conditioner.md
# coin_conditioner

Front-end stage that feeds the vending-machine FSM its coin inputs. It converts three raw, asynchronous, bouncy coin-sensor lines (nickel, dime, quarter) into clean single-cycle pulses on N, D and Q. At most one pulse is emitted per clock, so coins inserted together reach the FSM one at a time. Coins arriving while the FSM is busy are queued per denomination, with a sticky flag for lost coins.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced state before that state changes; legal range 2..15.
- PEND_MAX, 3: saturation value of each per-denomination pending counter; counters are 2 bits wide.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- n_raw  input  1  nickel sensor, asynchronous, active-high, may bounce.
- d_raw  input  1  dime sensor, same properties as n_raw.
- q_raw  input  1  quarter sensor, same properties as n_raw.
- hold  input  1  downstream busy signal; while 1, no pulses are emitted.
- N  output  1  nickel pulse, one cycle wide, registered.
- D  output  1  dime pulse, one cycle wide, registered.
- Q  output  1  quarter pulse, one cycle wide, registered.
- coin_pending  output  1  1 when any pending counter is nonzero, registered.
- overflow  output  1  sticky; set when a coin is lost to saturation, cleared only by reset.

## Operation
- Per channel: 2-flop synchronizer (s1 to s2), then a debounce counter and a stable bit.
- Debounce:
  - If s2 == stable, the counter clears.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, stable <= s2 and the counter clears; else the counter increments.
- Coin event: the edge on which stable goes 0 to 1. Falling transitions are debounced identically but generate no event.
- Pending counters:
  - A coin event increments the channel's counter.
  - An emission decrements it.
  - If both happen on the same edge, the counter is unchanged.
  - If an event arrives with the counter at PEND_MAX and no emission that edge, the counter stays at PEND_MAX and overflow <= 1.
- Emission, evaluated each edge:
  - If hold == 0 and any counter is nonzero, exactly one of N/D/Q is registered high, chosen by fixed priority Q > D > N, and that counter decrements. The other two outputs are registered 0.
  - If hold == 1 or all counters are zero, N, D and Q are registered 0.
- N, D and Q are mutually exclusive every cycle.
- coin_pending reflects the counters after the current edge's update.
- Reset (reset == 0 at an edge): s1, s2, stable, debounce counters, pending counters, N, D, Q, coin_pending and overflow all become 0.
  - Reset mid-operation discards all pending coins.
  - A sensor held high through reset re-debounces after release and produces one new coin event.

## Timing
- Latency: raw input rises and stays high from before edge k. Then s2 = 1 after edge k+1, stable = 1 and pending increments at edge k+DEBOUNCE_CYCLES+1, and the pulse is high during the cycle after edge k+DEBOUNCE_CYCLES+2. This assumes hold == 0 and no higher-priority coin is pending.
- A high glitch lasting fewer than DEBOUNCE_CYCLES+? cycles at s2 does not reach stable. Precisely: fewer than DEBOUNCE_CYCLES consecutive mismatch edges means no event.
- Pulse width is exactly one cycle. Back-to-back pulses (same or different channel) may appear on consecutive cycles.
- hold is sampled at the same edge that would register the pulse. Asserting hold suppresses the pulse from the next cycle onward; no pulse is lost, it remains pending.
- Emission resumes on the first edge where hold == 0.

## Test plan
- Single nickel: reset low 2 cycles, then n_raw high 10 cycles with DEBOUNCE_CYCLES=4 -> exactly one N pulse, 7 edges after n_raw rises (k+6); D, Q and overflow stay 0.
- Bounce rejection: d_raw toggling 1,0,1,0 each cycle, then low -> no D pulse. Then d_raw high 8 cycles -> one D pulse.
- Simultaneous coins: n_raw, d_raw and q_raw rise on the same cycle and hold 10 cycles -> Q, D, N pulses on three consecutive cycles, in that order; coin_pending falls with the N pulse.
- Hold queuing: hold = 1, then two quarters inserted (high 6 / low 6 each) -> no pulses and coin_pending = 1. Release hold -> two Q pulses on consecutive cycles, then coin_pending = 0.
- Saturation: hold = 1, four nickels inserted -> overflow = 1 after the fourth event. Release hold -> exactly three N pulses; overflow remains 1.
- Reset mid-queue: two dimes pending under hold, then reset = 0 for one edge -> all outputs 0. Release hold -> no D pulses.
